// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: byte-addressed Avalon-MM memory model with reset-vector window, wait states and sticky error
module avalon_mem_slave #(
  parameter int          DEPTH_BYTES = 4096,
  parameter logic [31:0] HIGH_BASE   = 32'hBFC00000,
  parameter int          HIGH_OFFSET = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter bit          BIG_ENDIAN  = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [31:0] lat_addr, lat_wd;
  logic [3:0] lat_be;
  logic lat_rd, lat_wr;
  logic [7:0] mem [DEPTH_BYTES];
  logic req, src_rd, src_wr, in_range, abort, set_err;
  logic [31:0] src_addr, word_addr, idx, rword;
  logic [AW-1:0] base;
  assign req = read | write;
  assign waitrequest = req & (state != ACK);
  // In IDLE the live request is decoded so a zero-wait access can complete without a latched copy
  always_comb begin
    src_addr = state == IDLE ? address : lat_addr;
    src_rd = state == IDLE ? read : lat_rd;
    src_wr = state == IDLE ? write : lat_wr;
    word_addr = {src_addr[31:2], 2'b00};
    idx = word_addr >= HIGH_BASE ? word_addr - HIGH_BASE + 32'(HIGH_OFFSET) : word_addr;
    in_range = {1'b0, idx} + 33'd3 < 33'(DEPTH_BYTES);
    base = in_range ? idx[AW-1:0] : '0;
    abort = state == BUSY & (!req | address != lat_addr | read != lat_rd | write != lat_wr);
    nxt = state == ACK ? IDLE
        : state == BUSY ? (abort ? IDLE : cnt == 4'd0 ? ACK : BUSY)
        : !req ? IDLE : WAIT_CYCLES == 0 ? ACK : BUSY;
    set_err = (state == IDLE & req & |src_addr[1:0]) | (nxt == ACK & (!in_range | (src_rd & src_wr))) | abort;
    rword = '0;
    for (int l = 0; l < 4; l++) rword[8*l +: 8] = mem[base + AW'(BIG_ENDIAN ? 3 - l : l)];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      readdata <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE & req) begin
        lat_addr <= address;
        lat_rd <= read;
        lat_wr <= write;
        lat_be <= byteenable;
        lat_wd <= writedata;
        cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == BUSY & cnt != 4'd0) cnt <= cnt - 4'd1;
      if (nxt == ACK & src_rd) readdata <= (src_wr | !in_range) ? '0 : rword;
      if (set_err) err <= 1'b1;
    end
  end
  // Writes land on the edge that ends ACK; in ACK the decode uses the latched address
  always_ff @(posedge clk) begin
    if (!reset & state == ACK & lat_wr & !lat_rd & in_range)
      for (int l = 0; l < 4; l++)
        if (lat_be[l]) mem[base + AW'(BIG_ENDIAN ? 3 - l : l)] <= lat_wd[8*l +: 8];
  end
endmodule

// File: tb/tb_avalon_mem_slave.sv
// tb_avalon_mem_slave: directed checks on three configurations (0/3/2 wait states, big/big/little endian)
module tb_avalon_mem_slave;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] address [3];
  logic [31:0] writedata [3];
  logic [31:0] readdata [3];
  logic [3:0] byteenable [3];
  logic read [3];
  logic write [3];
  logic waitrequest [3];
  logic err [3];
  int n_cmp = 0;
  int n_bad = 0;
  int hi;
  logic [31:0] rd;
  always #5 clk = ~clk;
  avalon_mem_slave #(.WAIT_CYCLES(0), .BIG_ENDIAN(1)) u0 (
    .clk(clk), .reset(reset), .address(address[0]), .read(read[0]), .write(write[0]),
    .byteenable(byteenable[0]), .writedata(writedata[0]), .waitrequest(waitrequest[0]),
    .readdata(readdata[0]), .err(err[0]));
  avalon_mem_slave #(.WAIT_CYCLES(3), .BIG_ENDIAN(1)) u1 (
    .clk(clk), .reset(reset), .address(address[1]), .read(read[1]), .write(write[1]),
    .byteenable(byteenable[1]), .writedata(writedata[1]), .waitrequest(waitrequest[1]),
    .readdata(readdata[1]), .err(err[1]));
  avalon_mem_slave #(.WAIT_CYCLES(2), .BIG_ENDIAN(0)) u2 (
    .clk(clk), .reset(reset), .address(address[2]), .read(read[2]), .write(write[2]),
    .byteenable(byteenable[2]), .writedata(writedata[2]), .waitrequest(waitrequest[2]),
    .readdata(readdata[2]), .err(err[2]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Drives one request and holds it until waitrequest drops; returns cycles spent waiting and readdata in ACK
  task automatic xfer(input int d, input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, output int n_hi, output logic [31:0] rdata);
    logic done;
    address[d] = a;
    byteenable[d] = be;
    writedata[d] = wd;
    read[d] = r;
    write[d] = w;
    n_hi = 0;
    rdata = '0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!waitrequest[d]) begin
        rdata = readdata[d];
        done = 1'b1;
      end else n_hi++;
    end
    if (!done) check("handshake_timeout", 32'(n_hi), 32'd0);
    @(posedge clk);
    #1;
    read[d] = 1'b0;
    write[d] = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int d = 0; d < 3; d++) begin
      address[d] = '0;
      writedata[d] = '0;
      byteenable[d] = '0;
      read[d] = 1'b0;
      write[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait", 32'(waitrequest[0]), 32'd0);
    check("rst_rdata", readdata[0], 32'd0);
    check("rst_err", 32'(err[1]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // zero-wait, high window
    xfer(0, 1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h8C010064, hi, rd);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, hi, rd);
    check("w0_lat", 32'(hi), 32'd1);
    check("w0_hi_rd", rd, 32'h8C010064);
    check("w0_err", 32'(err[0]), 32'd0);
    xfer(0, 1'b0, 1'b1, 32'hBFC007FC, 4'hF, 32'h12345678, hi, rd);
    xfer(0, 1'b1, 1'b0, 32'hBFC007FC, 4'h0, 32'h0, hi, rd);
    check("top_word", rd, 32'h12345678);
    check("top_err", 32'(err[0]), 32'd0);
    // 3 wait states, big endian
    xfer(1, 1'b0, 1'b1, 32'd200, 4'hF, 32'h000001A8, hi, rd);
    check("w3_wr_lat", 32'(hi), 32'd4);
    xfer(1, 1'b1, 1'b0, 32'd200, 4'h0, 32'h0, hi, rd);
    check("w3_rd_lat", 32'(hi), 32'd4);
    check("w3_rd", rd, 32'h000001A8);
    check("be_byte203", 32'(u1.mem[203]), 32'hA8);
    xfer(1, 1'b0, 1'b1, 32'd408, 4'hF, 32'hAABBCCDD, hi, rd);
    xfer(1, 1'b0, 1'b1, 32'd408, 4'b0101, 32'h11223344, hi, rd);
    xfer(1, 1'b1, 1'b0, 32'd408, 4'h0, 32'h0, hi, rd);
    check("lanes_big", rd, 32'hAA22CC44);
    xfer(1, 1'b0, 1'b1, 32'd408, 4'h0, 32'hFFFFFFFF, hi, rd);
    xfer(1, 1'b1, 1'b0, 32'd408, 4'h0, 32'h0, hi, rd);
    check("be_zero", rd, 32'hAA22CC44);
    check("w3_err", 32'(err[1]), 32'd0);
    xfer(1, 1'b1, 1'b1, 32'd200, 4'hF, 32'hFFFFFFFF, hi, rd);
    check("both_rd", rd, 32'd0);
    check("both_err", 32'(err[1]), 32'd1);
    xfer(1, 1'b1, 1'b0, 32'd200, 4'h0, 32'h0, hi, rd);
    check("both_nocommit", rd, 32'h000001A8);
    // 2 wait states, little endian
    xfer(2, 1'b0, 1'b1, 32'd408, 4'hF, 32'hAABBCCDD, hi, rd);
    check("w2_lat", 32'(hi), 32'd3);
    xfer(2, 1'b0, 1'b1, 32'd408, 4'b0101, 32'h11223344, hi, rd);
    xfer(2, 1'b1, 1'b0, 32'd408, 4'h0, 32'h0, hi, rd);
    check("lanes_little", rd, 32'hAA22CC44);
    check("le_byte408", 32'(u2.mem[408]), 32'h44);
    xfer(2, 1'b0, 1'b1, 32'd100, 4'hF, 32'h01020304, hi, rd);
    check("le_err_clean", 32'(err[2]), 32'd0);
    address[2] = 32'd100;
    writedata[2] = 32'hDEADBEEF;
    byteenable[2] = 4'hF;
    write[2] = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy_wait", 32'(waitrequest[2]), 32'd1);
    write[2] = 1'b0;
    @(posedge clk);
    #1;
    xfer(2, 1'b1, 1'b0, 32'd100, 4'h0, 32'h0, hi, rd);
    check("abort_nocommit", rd, 32'h01020304);
    check("abort_err", 32'(err[2]), 32'd1);
    // out of range on the zero-wait instance
    xfer(0, 1'b1, 1'b0, 32'h00002000, 4'h0, 32'h0, hi, rd);
    check("oor_lat", 32'(hi), 32'd1);
    check("oor_rd", rd, 32'd0);
    check("oor_err", 32'(err[0]), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, hi, rd);
    check("err_sticky", 32'(err[0]), 32'd1);
    // reset landing in ACK of a write
    address[1] = 32'd200;
    writedata[1] = 32'h55555555;
    byteenable[1] = 4'hF;
    write[1] = 1'b1;
    hi = 0;
    for (int i = 0; i < 40 && waitrequest[1]; i++) begin
      @(negedge clk);
      if (waitrequest[1]) hi++;
    end
    check("rst_ack_seen", 32'(waitrequest[1]), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    write[1] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_rdata", readdata[1], 32'd0);
    check("rst2_err1", 32'(err[1]), 32'd0);
    check("rst2_err0", 32'(err[0]), 32'd0);
    @(posedge clk);
    #1;
    xfer(1, 1'b1, 1'b0, 32'd200, 4'h0, 32'h0, hi, rd);
    check("rst2_lat", 32'(hi), 32'd4);
    check("rst2_storage", rd, 32'h000001A8);
    check("rst2_clean", 32'(err[1]), 32'd0);
    xfer(1, 1'b1, 1'b0, 32'd202, 4'h0, 32'h0, hi, rd);
    check("misalign_rd", rd, 32'h000001A8);
    check("misalign_err", 32'(err[1]), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'h0, hi, rd);
    check("storage_kept", rd, 32'h8C010064);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
